// File: rtl/fs18_bus_pkg.sv
// Shared FS18 bus definitions: default widths, arbiter state encoding, port indices.
// Reused by FS18 bus masters and slaves.
package fs18_bus_pkg;

  localparam int FS18_AW = 18;
  localparam int FS18_DW = 18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LSU   = 1'b1;

  // Round-robin pick: a lone requester wins, otherwise the favoured port.
  function automatic logic pick_port(input logic r0, input logic r1, input logic prio);
    if (r0 && r1) return prio;
    return r0 ? PORT_FETCH : PORT_LSU;
  endfunction

endpackage

// File: rtl/fs18_arb_watchdog.sv
// BUSY-cycle watchdog for the FS18 arbiter: counts stalled BUSY cycles and flags
// the cycle in which the TIMEOUT-th stalled cycle is reached.
module fs18_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // cnt_q holds the number of stalled BUSY cycles already elapsed.
  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/fs18_mem_arbiter.sv
// Two-port round-robin arbiter (fetch / LSU) onto the single-port FS18 memory bus.
// Optional BUSY watchdog compiled in with FS18_ARB_WATCHDOG_EN.
module fs18_mem_arbiter
  import fs18_bus_pkg::*;
#(
  parameter int AW      = FS18_AW,
  parameter int DW      = FS18_DW,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  arb_state_e    state_q, state_d;
  logic          owner_q, owner_d;
  logic          prio_q, prio_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic          err_q, err_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          sel;
  logic          timeout;

`ifdef FS18_ARB_WATCHDOG_EN
  logic wd_expired;

  fs18_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q != ST_BUSY),
    .en      ((state_q == ST_BUSY) && !mem_ack),
    .expired (wd_expired)
  );

  assign timeout = (state_q == ST_BUSY) && wd_expired;
`else
  logic [15:0] wd_unused_timeout;
  assign wd_unused_timeout = 16'(TIMEOUT);
  assign timeout           = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    prio_d      = prio_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    gnt_d       = '0;
    done_d      = '0;
    err_d       = 1'b0;
    mem_req_d   = 1'b0;
    sel         = pick_port(req0, req1, prio_q);
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          owner_d     = sel;
          mem_we_d    = sel ? we1    : we0;
          mem_addr_d  = sel ? addr1  : addr0;
          mem_wdata_d = sel ? wdata1 : wdata0;
          gnt_d[sel]  = 1'b1;
          mem_req_d   = 1'b1;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        gnt_d[owner_q] = 1'b1;
        // A same-cycle ack beats the watchdog.
        if (mem_ack) begin
          rdata_d         = mem_rdata;
          done_d[owner_q] = 1'b1;
          state_d         = ST_RESP;
        end else if (timeout) begin
          rdata_d         = '0;
          err_d           = 1'b1;
          done_d[owner_q] = 1'b1;
          state_d         = ST_RESP;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      ST_RESP: begin
        prio_d  = ~owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      prio_q      <= 1'b0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      prio_q      <= prio_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign gnt0      = gnt_q[0];
  assign gnt1      = gnt_q[1];
  assign done0     = done_q[0];
  assign done1     = done_q[1];
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
